pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter ADDR_WIDTH SHALL default to 12: program address width, equal to the program counter's width.
REQ-003 Parameter STACK_DEPTH SHALL default to 4: return-stack entries, power of two, minimum 2.
REQ-004 Parameter IRQ_VECTOR SHALL default to 12'h004: interrupt entry address.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 arst  in  1  asynchronous active-high reset.
REQ-007 en  in  1  run enable; low freezes FSM, stack and flags.
REQ-008 mem_ready  in  1  instruction fetch data valid.
REQ-009 op  in  3  decoded flow op: 0 SEQ, 1 JMP, 2 BZ, 3 CALL, 4 RET, 5 RETI, 6 HALT, 7 treated as SEQ.
REQ-010 cond  in  1  branch condition for BZ (taken when 1).
REQ-011 target  in  ADDR_WIDTH  JMP/BZ/CALL destination.
REQ-012 pc_cur  in  ADDR_WIDTH  current program counter value.
REQ-013 irq  in  1  level interrupt request.
REQ-014 pc_inc, pc_load  out  1 each  program counter strobes; never both high.
REQ-015 pc_next  out  ADDR_WIDTH  load address; 0 when pc_load low.
REQ-016 fetch_req  out  1  request instruction at pc_cur.
REQ-017 exec_en  out  1  one-cycle datapath execute strobe.
REQ-018 irq_ack, halted, stack_err  out  1 each  interrupt taken pulse; in HALT; sticky stack fault.

Function
REQ-019 FSM states SHALL be FETCH, EXEC, IRQ, HALT; all outputs combinational from state and inputs except stack_err (registered).
REQ-020 FETCH SHALL assert fetch_req; mem_ready=1 -> EXEC next cycle; else remain.
REQ-021 EXEC SHALL last exactly one cycle with exec_en=1 and apply op in that cycle.
REQ-022 SEQ, and BZ with cond=0: pc_inc=1.
REQ-023 JMP, and BZ with cond=1: pc_load=1, pc_next=target.
REQ-024 CALL, stack not full: push (pc_cur+1) mod 2^ADDR_WIDTH, pc_load=1, pc_next=target.
REQ-025 RET/RETI, stack not empty: pop, pc_load=1, pc_next=popped value; RETI also sets ie.
REQ-026 CALL on full or RET/RETI on empty: no stack change, pc_inc=1, stack_err set (sticky), ie unchanged.
REQ-027 HALT op: no pc strobe; next state HALT, halted=1 in HALT.
REQ-028 After EXEC of a non-HALT op, next state SHALL be IRQ if irq=1, ie=1 and stack not full after this EXEC's push/pop; otherwise FETCH.
REQ-029 In HALT: irq=1, ie=1, stack not full -> IRQ; otherwise remain.
REQ-030 IRQ state, one cycle: push pc_cur (already updated), pc_load=1, pc_next=IRQ_VECTOR, irq_ack=1, clear ie; next FETCH.
REQ-031 Interrupt with stack full SHALL be deferred, not dropped, and SHALL not set stack_err.
REQ-032 en=0: state, stack, ie, stack_err hold; pc_inc, pc_load, fetch_req, exec_en, irq_ack all 0.
REQ-033 Stack pointer SHALL count 0..STACK_DEPTH; full at STACK_DEPTH, empty at 0; no wrap.

Reset
REQ-034 arst SHALL force state FETCH, stack pointer 0, ie=1, stack_err=0 immediately, irrespective of clk.
REQ-035 During reset all strobes SHALL be 0 and pc_next 0; reset mid-EXEC or mid-IRQ SHALL discard any pending push.
REQ-036 Stack contents need no reset.

Structure
REQ-037 Op encodings and state encodings SHALL live in shared package uc_pkg.
REQ-038 The return stack SHALL be a sub-module return_stack (push, pop, data, full, empty).

Verification
REQ-039 Reset, en=1, mem_ready=1, op=SEQ x3 -> pc_inc pulses every second cycle; pc advances 0,1,2,3.
REQ-040 pc_cur=12'h010, op=CALL, target=12'h200; later op=RET -> push 12'h011; RET gives pc_load, pc_next=12'h011.
REQ-041 Five nested CALLs, STACK_DEPTH=4 -> fifth: pc_inc=1, no load, stack_err=1 and stays 1 until arst.
REQ-042 irq=1 during EXEC of SEQ at pc_cur=12'h020 -> IRQ next cycle, pc_next=12'h004, irq_ack one cycle, pushed 12'h021; second irq ignored until RETI.
REQ-043 op=HALT -> halted=1, no strobes for 10 cycles; irq=1 -> IRQ, pc_next=12'h004, halted=0.
REQ-044 arst asserted mid-FETCH between clock edges -> outputs 0 immediately; after release FSM in FETCH, fetch_req=1.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the program-flow sequencer: decoded flow ops and FSM states.
package uc_pkg;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BZ   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_RETI = 3'd5,
        OP_HALT = 3'd6,
        OP_RSV  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_IRQ   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    function automatic logic is_return(input op_e op);
        return (op == OP_RET) || (op == OP_RETI);
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; pointer counts 0..DEPTH and never wraps, contents are not reset.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic         almost_full
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [SPW-1:0] sp_q, sp_d;
    logic [W-1:0]   mem_q [DEPTH];
    logic [IW-1:0]  rd_idx;

    assign full        = (sp_q == SPW'(DEPTH));
    assign empty       = (sp_q == '0);
    assign almost_full = (sp_q == SPW'(DEPTH - 1));
    assign rd_idx      = sp_q[IW-1:0] - IW'(1);
    assign pop_data    = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow sequencer: fetch/execute/interrupt FSM driving program-counter strobes,
// with a hardware return stack for CALL/RET and interrupt entry.
module pc_sequencer
    import uc_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR  = 'h004
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  en,
    input  logic                  mem_ready,
    input  logic [2:0]            op,
    input  logic                  cond,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic [ADDR_WIDTH-1:0] pc_cur,
    input  logic                  irq,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  fetch_req,
    output logic                  exec_en,
    output logic                  irq_ack,
    output logic                  halted,
    output logic                  stack_err
);

    state_e state_q, state_d;
    logic   ie_q, ie_d;
    logic   err_q, err_d;

    op_e                   op_w;
    logic                  st_push, st_pop;
    logic [ADDR_WIDTH-1:0] st_push_data, st_pop_data;
    logic                  st_full, st_empty, st_almost_full;
    logic                  full_after;

    assign op_w      = op_e'(op);
    assign stack_err = err_q;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_WIDTH)
    ) u_stack (
        .clk         (clk),
        .arst        (arst),
        .push        (st_push),
        .pop         (st_pop),
        .push_data   (st_push_data),
        .pop_data    (st_pop_data),
        .full        (st_full),
        .empty       (st_empty),
        .almost_full (st_almost_full)
    );

    // Reset is folded in combinationally so strobes drop the instant arst rises.
    always_comb begin
        state_d      = state_q;
        ie_d         = ie_q;
        err_d        = err_q;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        pc_next      = '0;
        fetch_req    = 1'b0;
        exec_en      = 1'b0;
        irq_ack      = 1'b0;
        st_push      = 1'b0;
        st_pop       = 1'b0;
        st_push_data = '0;
        full_after   = st_full;
        halted       = (state_q == ST_HALT) && !arst;

        if (!arst && en) begin
            unique case (state_q)
                ST_FETCH: begin
                    fetch_req = 1'b1;
                    if (mem_ready) state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    exec_en = 1'b1;
                    unique case (op_w)
                        OP_JMP: begin
                            pc_load = 1'b1;
                            pc_next = target;
                        end
                        OP_BZ: begin
                            if (cond) begin
                                pc_load = 1'b1;
                                pc_next = target;
                            end else begin
                                pc_inc = 1'b1;
                            end
                        end
                        OP_CALL: begin
                            if (!st_full) begin
                                st_push      = 1'b1;
                                st_push_data = pc_cur + ADDR_WIDTH'(1);
                                pc_load      = 1'b1;
                                pc_next      = target;
                                full_after   = st_almost_full;
                            end else begin
                                pc_inc = 1'b1;
                                err_d  = 1'b1;
                            end
                        end
                        OP_RET, OP_RETI: begin
                            if (!st_empty) begin
                                st_pop     = 1'b1;
                                pc_load    = 1'b1;
                                pc_next    = st_pop_data;
                                full_after = 1'b0;
                                if (op_w == OP_RETI) ie_d = 1'b1;
                            end else begin
                                pc_inc = 1'b1;
                                err_d  = 1'b1;
                            end
                        end
                        OP_HALT: ;
                        default: pc_inc = 1'b1;
                    endcase
                    // Interrupt is taken only if the stack can still absorb the return address.
                    if (op_w == OP_HALT) begin
                        state_d = ST_HALT;
                    end else if (irq && ie_d && !full_after) begin
                        state_d = ST_IRQ;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_IRQ: begin
                    st_push      = !st_full;
                    st_push_data = pc_cur;
                    pc_load      = 1'b1;
                    pc_next      = IRQ_VECTOR;
                    irq_ack      = 1'b1;
                    ie_d         = 1'b0;
                    state_d      = ST_FETCH;
                end
                ST_HALT: begin
                    if (irq && ie_q && !st_full) state_d = ST_IRQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_FETCH;
            ie_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            err_q   <= err_d;
        end
    end

endmodule
